// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: FSM states,
// opcode/funct constants, instruction classes and datapath select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_ORI  = 4'd3,
        CL_LW   = 4'd4,
        CL_SW   = 4'd5,
        CL_BEQ  = 4'd6,
        CL_LUI  = 4'd7,
        CL_J    = 4'd8
    } iclass_t;

    localparam logic [1:0] EOP_SIGN   = 2'd0;
    localparam logic [1:0] EOP_ZERO   = 2'd1;
    localparam logic [1:0] EOP_HI16   = 2'd2;
    localparam logic [1:0] EOP_SHL2   = 2'd3;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_OR     = 2'd2;
    localparam logic [1:0] ALU_PASSB  = 2'd3;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_EXT   = 2'd2;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    // Extender mode chosen in EXEC; MEM/WB keep presenting it so the
    // immediate path stays stable for the whole back half of the instruction.
    function automatic logic [1:0] exec_eop(input iclass_t cls);
        logic [1:0] e;
        case (cls)
            CL_ORI:  e = EOP_ZERO;
            CL_LUI:  e = EOP_HI16;
            default: e = EOP_SIGN;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps opcode/funct to an instruction
// class and flags encodings outside the supported subset.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] iclass,
    output logic       illegal
);

    // Opcode/funct lookup; unknown encodings become nop with illegal raised.
    always_comb begin
        iclass  = CL_NOP;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: iclass = CL_ADDU;
                    FN_SUBU: iclass = CL_SUBU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ORI:  iclass = CL_ORI;
            OP_LW:   iclass = CL_LW;
            OP_SW:   iclass = CL_SW;
            OP_BEQ:  iclass = CL_BEQ;
            OP_LUI:  iclass = CL_LUI;
            OP_J:    iclass = CL_J;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving the
// datapath enables and selects, plus a retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  eop,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic        reg_dst,
    output logic        wd_sel,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    state_t      state_r;
    state_t      next_s;
    iclass_t     class_r;
    logic [31:0] cnt_r;

    logic [3:0]  dec_class_s;
    logic        dec_illegal_s;

    logic        pc_we_s;
    logic        ir_we_s;
    logic        reg_we_s;
    logic        mem_we_s;
    logic        done_s;
    logic        illegal_s;

    mc_decode u_decode (
        .op      (op),
        .funct   (funct),
        .iclass  (dec_class_s),
        .illegal (dec_illegal_s)
    );

    // State register; reset always restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Latch the decoded class at the end of DECODE so later states ignore IR.
    always_ff @(posedge clk) begin
        if (!reset) begin
            class_r <= CL_NOP;
        end else if (state_r == ST_DECODE) begin
            class_r <= iclass_t'(dec_class_s);
        end else begin
            class_r <= class_r;
        end
    end

    // Retired-instruction counter, naturally wrapping at 32 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= 32'd0;
        end else if (done_s) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state and per-state datapath controls; only DECODE looks at live
    // op/funct and only beq's EXEC looks at zero.
    always_comb begin
        next_s    = state_r;
        pc_we_s   = 1'b0;
        ir_we_s   = 1'b0;
        reg_we_s  = 1'b0;
        mem_we_s  = 1'b0;
        done_s    = 1'b0;
        illegal_s = 1'b0;
        eop       = EOP_SIGN;
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_RT;
        pc_src    = PCS_ALU;
        reg_dst   = 1'b0;
        wd_sel    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ir_we_s   = 1'b1;
                pc_we_s   = 1'b1;
                alu_src_b = SRCB_FOUR;
                next_s    = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_EXT;
                eop       = EOP_SHL2;
                if (dec_illegal_s) begin
                    illegal_s = 1'b1;
                    done_s    = 1'b1;
                    next_s    = ST_FETCH;
                end else if (iclass_t'(dec_class_s) == CL_J) begin
                    pc_we_s   = 1'b1;
                    pc_src    = PCS_JUMP;
                    done_s    = 1'b1;
                    next_s    = ST_FETCH;
                end else begin
                    next_s    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                eop    = exec_eop(class_r);
                next_s = ST_WB;
                case (class_r)
                    CL_ADDU: begin
                        alu_src_a = 1'b1;
                    end
                    CL_SUBU: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_SUB;
                    end
                    CL_ORI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_EXT;
                        alu_op    = ALU_OR;
                    end
                    CL_LUI: begin
                        alu_src_b = SRCB_EXT;
                        alu_op    = ALU_PASSB;
                    end
                    CL_LW, CL_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_EXT;
                        next_s    = ST_MEM;
                    end
                    CL_BEQ: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_SUB;
                        pc_src    = PCS_ALUOUT;
                        pc_we_s   = zero;
                        done_s    = 1'b1;
                        next_s    = ST_FETCH;
                    end
                    default: next_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                eop = exec_eop(class_r);
                if (class_r == CL_LW) begin
                    next_s = ST_WB;
                end else if (class_r == CL_SW) begin
                    mem_we_s = 1'b1;
                    done_s   = 1'b1;
                    next_s   = ST_FETCH;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_WB: begin
                eop      = exec_eop(class_r);
                reg_we_s = 1'b1;
                done_s   = 1'b1;
                next_s   = ST_FETCH;
                if (class_r == CL_ADDU || class_r == CL_SUBU) begin
                    reg_dst = 1'b1;
                end else begin
                    reg_dst = 1'b0;
                end
                if (class_r == CL_LW) begin
                    wd_sel = 1'b1;
                end else begin
                    wd_sel = 1'b0;
                end
            end
            default: next_s = ST_FETCH;
        endcase
    end

    // Write enables and pulses are suppressed while reset is held low.
    assign pc_we      = reset & pc_we_s;
    assign ir_we      = reset & ir_we_s;
    assign reg_we     = reset & reg_we_s;
    assign mem_we     = reset & mem_we_s;
    assign instr_done = reset & done_s;
    assign illegal    = reset & illegal_s;
    assign instr_cnt  = cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instruction streams
// checked cycle by cycle against a per-instruction schedule model.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_we;
        logic [1:0] eop;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       wd_sel;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LW = 3, K_SW = 4;
    localparam int K_BEQ = 5, K_LUI = 6, K_J = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        pc_we, ir_we, reg_we, mem_we, alu_src_a, reg_dst, wd_sel;
    logic        instr_done, illegal;
    logic [1:0]  eop, alu_op, alu_src_b, pc_src;
    logic [31:0] instr_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_cnt = 32'd0;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .eop        (eop),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .wd_sel     (wd_sel),
        .instr_done (instr_done),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ilen(input int kind);
        case (kind)
            K_J, K_ILL: return 2;
            K_BEQ:      return 3;
            K_LW:       return 5;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_legal_op(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b001101) || (o == 6'b100011) ||
               (o == 6'b101011) || (o == 6'b000100) || (o == 6'b001111) ||
               (o == 6'b000010);
    endfunction

    // Expected outputs for cycle k (0 = first cycle) of an instruction.
    function automatic outs_t exp_out(input int kind, input int k, input logic zb);
        outs_t o;
        o = '0;
        if (k == 0) begin
            o.pc_we = 1'b1; o.ir_we = 1'b1; o.alu_src_b = 2'd1;
        end else if (k == 1) begin
            o.alu_src_b = 2'd2; o.eop = 2'd3;
            if (kind == K_J) begin
                o.pc_we = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1;
            end
            if (kind == K_ILL) begin
                o.illegal = 1'b1; o.instr_done = 1'b1;
            end
        end else begin
            o.eop = (kind == K_ORI) ? 2'd1 : (kind == K_LUI) ? 2'd2 : 2'd0;
            if (k == 2) begin
                o.alu_src_a = (kind != K_LUI);
                o.alu_src_b = (kind == K_ADDU || kind == K_SUBU || kind == K_BEQ) ? 2'd0 : 2'd2;
                o.alu_op    = (kind == K_SUBU || kind == K_BEQ) ? 2'd1 :
                              (kind == K_ORI) ? 2'd2 : (kind == K_LUI) ? 2'd3 : 2'd0;
                if (kind == K_BEQ) begin
                    o.pc_src = 2'd1; o.pc_we = zb; o.instr_done = 1'b1;
                end
            end else if (k == 3 && kind == K_SW) begin
                o.mem_we = 1'b1; o.instr_done = 1'b1;
            end else if (k == 3 && kind == K_LW) begin
                o = o;
            end else begin
                o.reg_we = 1'b1; o.instr_done = 1'b1;
                o.reg_dst = (kind == K_ADDU || kind == K_SUBU);
                o.wd_sel  = (kind == K_LW);
            end
        end
        return o;
    endfunction

    // Drive one instruction for ncyc cycles (full length retires it).
    task automatic run_instr(input int kind, input logic [5:0] op_v,
                             input logic [5:0] fn_v, input logic zb,
                             input int ncyc, input string tag);
        outs_t got, exp;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k <= 1) begin
                op = op_v; funct = fn_v;
            end else begin
                op = 6'($urandom); funct = 6'($urandom);
            end
            zero = (k == 2) ? zb : 1'($urandom);
            #1;
            got = {pc_we, ir_we, reg_we, mem_we, eop, alu_op, alu_src_a,
                   alu_src_b, pc_src, reg_dst, wd_sel, instr_done, illegal};
            exp = exp_out(kind, k, zb);
            n_cmp++;
            assert (got === exp) else begin
                n_bad++;
                $error("FAIL %s cyc%0d outs got=%h exp=%h", tag, k, got, exp);
            end
            n_cmp++;
            assert (instr_cnt === model_cnt) else begin
                n_bad++;
                $error("FAIL %s cyc%0d instr_cnt got=%h exp=%h", tag, k, instr_cnt, model_cnt);
            end
        end
        if (ncyc == ilen(kind)) model_cnt = model_cnt + 32'd1;
    endtask

    // Hold reset low for three cycles starting now; enables must stay quiet.
    task automatic reset_hold(input string tag);
        logic [5:0] en;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (r == 0) reset = 1'b0;
            #1;
            en = {pc_we, ir_we, reg_we, mem_we, instr_done, illegal};
            n_cmp++;
            assert (en === 6'd0) else begin
                n_bad++;
                $error("FAIL %s rst%0d enables got=%b exp=000000", tag, r, en);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        model_cnt = 32'd0;
    endtask

    task automatic run_kind(input int kind, input logic zb, input string tag);
        logic [5:0] o, f;
        f = 6'($urandom);
        case (kind)
            K_ADDU:  begin o = 6'b000000; f = 6'b100001; end
            K_SUBU:  begin o = 6'b000000; f = 6'b100011; end
            K_ORI:   o = 6'b001101;
            K_LW:    o = 6'b100011;
            K_SW:    o = 6'b101011;
            K_BEQ:   o = 6'b000100;
            K_LUI:   o = 6'b001111;
            K_J:     o = 6'b000010;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'b000000;
                    while (f == 6'b100001 || f == 6'b100011) f = 6'($urandom);
                end else begin
                    o = 6'b111111;
                    for (int t = 0; t < 64; t++) begin
                        o = 6'($urandom);
                        if (!is_legal_op(o)) break;
                    end
                    if (is_legal_op(o)) o = 6'b111111;
                end
            end
        endcase
        run_instr(kind, o, f, zb, ilen(kind), tag);
    endtask

    initial begin
        // Power-on reset.
        reset_hold("por");

        run_kind(K_ADDU, 1'b0, "addu");
        run_kind(K_SUBU, 1'b0, "subu");
        run_kind(K_ORI,  1'b0, "ori");
        run_kind(K_LUI,  1'b0, "lui");
        run_kind(K_LW,   1'b0, "lw");
        run_kind(K_SW,   1'b0, "sw");
        run_kind(K_BEQ,  1'b1, "beq_taken");
        run_kind(K_BEQ,  1'b0, "beq_not");
        run_kind(K_J,    1'b0, "j");
        run_instr(K_ILL, 6'b111111, 6'b000000, 1'b0, 2, "op3f");

        // Reset in the middle of an lw (after DECODE, during EXEC).
        run_instr(K_LW, 6'b100011, 6'b000000, 1'b0, 2, "lw_abort");
        reset_hold("mid_lw");
        run_kind(K_ADDU, 1'b0, "after_rst");

        // Random instruction stream.
        for (int i = 0; i < 40; i++) begin
            run_kind(int'($urandom_range(0, 8)), 1'($urandom), "rand");
        end

        // Counter wrap: preload all-ones between instructions, retire a j.
        @(posedge clk);
        #1 force dut.cnt_r = 32'hFFFF_FFFF;
        #1 release dut.cnt_r;
        model_cnt = 32'hFFFF_FFFF;
        run_kind(K_J, 1'b0, "wrap");
        @(negedge clk);
        #1;
        n_cmp++;
        assert (instr_cnt === 32'd0) else begin
            n_bad++;
            $error("FAIL wrap_final instr_cnt got=%h exp=00000000", instr_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the single-issue MIPS-subset datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable and mux select, including the `EOp` mode of the immediate extender. It also counts retired instructions. It sits between the instruction register (opcode/funct) and the datapath (PC, IR, GRF, ALU, DM, extender).

## Interface
No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `op` input 6: IR[31:26].
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU equal flag, valid in EXEC.
- `pc_we` output 1: PC write enable.
- `ir_we` output 1: IR write enable.
- `reg_we` output 1: GRF write enable.
- `mem_we` output 1: DM write enable.
- `eop` output 2: extender mode. 0 = sign, 1 = zero, 2 = imm<<16, 3 = sign<<2.
- `alu_op` output 2: 0 = add, 1 = sub, 2 = or, 3 = pass B.
- `alu_src_a` output 1: 0 = PC, 1 = rs.
- `alu_src_b` output 2: 0 = rt, 1 = const 4, 2 = ext.
- `pc_src` output 2: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `wd_sel` output 1: 0 = ALUOut, 1 = MDR.
- `instr_done` output 1: one-cycle pulse on an instruction's last cycle.
- `illegal` output 1: one-cycle pulse in DECODE for an undefined encoding.
- `instr_cnt` output 32: retired-instruction count.

## Operation
- Supported encodings:
  - addu: op 000000, funct 100001.
  - subu: op 000000, funct 100011.
  - ori: op 001101.
  - lw: op 100011.
  - sw: op 101011.
  - beq: op 000100.
  - lui: op 001111.
  - j: op 000010.
  - Anything else (including R-type with another funct) is illegal.
- Instruction class is latched at the end of DECODE. EXEC/MEM/WB decode from the latched class, never from live `op`/`funct`.
- Default for every output not listed in a state: enables 0, selects 0, `eop` 0.
- FETCH: `ir_we`=1, `pc_we`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add, `pc_src`=0. Next state DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=2, `eop`=3, `alu_op`=add (branch target into ALUOut).
  - j: `pc_we`=1, `pc_src`=2, `instr_done`=1, next FETCH.
  - illegal: `illegal`=1, `instr_done`=1, next FETCH. Treated as nop and counted.
  - Otherwise: next EXEC.
- EXEC:
  - addu/subu: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=add/sub.
  - ori: `alu_src_a`=1, `alu_src_b`=2, `eop`=1, `alu_op`=or.
  - lui: `alu_src_b`=2, `eop`=2, `alu_op`=pass B.
  - lw/sw: `alu_src_a`=1, `alu_src_b`=2, `eop`=0, `alu_op`=add.
  - beq: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=sub, `pc_src`=1, `pc_we`=`zero` (the only Mealy output), `instr_done`=1, next FETCH.
  - lw/sw next MEM; others next WB.
  - `eop` is held at the EXEC value through MEM/WB of the same instruction.
- MEM:
  - lw: next WB.
  - sw: `mem_we`=1, `instr_done`=1, next FETCH.
- WB: `reg_we`=1, `instr_done`=1, next FETCH.
  - addu/subu: `reg_dst`=1, `wd_sel`=0.
  - ori/lui: `reg_dst`=0, `wd_sel`=0.
  - lw: `reg_dst`=0, `wd_sel`=1.
- `instr_cnt` increments by 1 on each cycle with `instr_done`=1 and wraps 0xFFFFFFFF→0.

## Timing
- Cycles per instruction: j 2, illegal 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- Reset:
  - `reset`=0 at a rising edge sets state=FETCH, clears the latched class to nop, and sets `instr_cnt`=0.
  - While `reset`=0, `pc_we`, `ir_we`, `reg_we`, `mem_we`, `instr_done` and `illegal` are forced to 0 combinationally.
  - Reset mid-instruction abandons it with no partial write in the reset cycle. The first FETCH begins in the cycle after `reset` returns to 1.
- All state and counter updates happen on the rising `clk` edge only. No combinational path from `op`/`funct` to outputs except in DECODE.
- beq with `zero`=0: `pc_we`=0 in EXEC, so PC keeps the PC+4 value written in FETCH.

## Structure
- Package `mc_pkg` holds:
  - the state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4);
  - opcode/funct constants;
  - the instruction-class enum;
  - `eop`, `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `mc_decode`: combinational `op`/`funct` → class and illegal flag.
- `mc_ctrl` holds the FSM, class register, output decode and counter.

## Test plan
- Reset hold: `reset`=0 for 3 cycles mid-lw, then release. All write enables are 0 during reset; FETCH (`ir_we`=1) on the first cycle after release; `instr_cnt`=0.
- addu/subu/ori/lui: `reg_we`=1 on the 4th cycle with the correct selects. `eop` values: ori 1, lui 2, addu/subu 0. `instr_cnt`=4 afterwards.
- lw then sw: lw shows `wd_sel`=1 and `reg_we` on cycle 5; sw shows `mem_we`=1 on cycle 4; `eop`=0 in EXEC for both.
- beq with `zero`=1 and `zero`=0: `pc_we`=1/0 respectively in EXEC, `pc_src`=1, `eop`=3 in DECODE, 3-cycle length.
- j, then `op`=111111: j `pc_we`=1 with `pc_src`=2 in DECODE. The undefined opcode pulses `illegal` for 1 cycle, returns to FETCH, and `instr_cnt` increments.
- Counter wrap: preload via 2^32−1 retirements (or force) and retire one more → `instr_cnt`=0.
